// File: rtl/data_memory_responder.sv
// Fixed-latency line memory behind the cache controller: accepts one line read or
// write, waits LATENCY edges, then commits and pulses ack_o for one cycle.
module data_memory_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);
    localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [7:0]  LAST_CNT     = 8'(LATENCY - 1);
    localparam logic        SINGLE_CYCLE = 1'(LATENCY == 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [7:0]             cnt_r;
    logic                   write_r;
    logic [DEPTH_LOG2-1:0]  idx_r;
    logic [255:0]           wdata_r;
    logic [255:0]           memory [0:DEPTH-1];

    logic [DEPTH_LOG2-1:0]  req_idx_s;
    logic                   commit_s;
    logic                   commit_write_s;
    logic [DEPTH_LOG2-1:0]  commit_idx_s;
    logic [255:0]           commit_data_s;
    logic                   unused_addr_s;

    assign req_idx_s     = addr_i[DEPTH_LOG2+4:5];
    assign unused_addr_s = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    // Pick the transaction that commits at the coming edge; a single-cycle build
    // commits straight from the request inputs on the accept edge.
    always_comb begin
        commit_s       = 1'b0;
        commit_write_s = write_r;
        commit_idx_s   = idx_r;
        commit_data_s  = wdata_r;
        case (state_r)
            IDLE: begin
                if (SINGLE_CYCLE && enable_i) begin
                    commit_s       = 1'b1;
                    commit_write_s = write_i;
                    commit_idx_s   = req_idx_s;
                    commit_data_s  = data_i;
                end else begin
                    commit_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == LAST_CNT) begin
                    commit_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: commit_s = 1'b0;
        endcase
    end

    // Request FSM, latency counter, latched command and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            write_r <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 256'd0;
            ack_o   <= 1'b0;
            data_o  <= 256'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable_i) begin
                        write_r <= write_i;
                        idx_r   <= req_idx_s;
                        wdata_r <= data_i;
                        cnt_r   <= 8'd1;
                        state_r <= SINGLE_CYCLE ? ACK : WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ACK;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ACK:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            ack_o <= commit_s;
            if (commit_s && !commit_write_s) begin
                data_o <= memory[commit_idx_s];
            end
        end
    end

    // Line array has no reset; a reset in flight suppresses the pending commit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit_s && commit_write_s) begin
            memory[commit_idx_s] <= commit_data_s;
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: LATENCY=10 and LATENCY=1 responders, expected acks queued at issue.
module tb_data_memory_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, wr = 1'b0, ack;
    logic [31:0]  addr = 32'd0;
    logic [255:0] din = 256'd0, dout;
    logic         en1 = 1'b0, wr1 = 1'b0, ack1;
    logic [31:0]  addr1 = 32'd0;
    logic [255:0] din1 = 256'd0, dout1;

    typedef struct {
        int           exp_cyc;
        logic [255:0] data;
    } exp_t;

    exp_t         sb10[$];
    exp_t         sb1[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [255:0] last_rd10 = 256'd0;
    logic [255:0] last_rd1 = 256'd0;
    logic         prev_ack10 = 1'b0;
    logic         prev_ack1 = 1'b0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_D5 = {8{32'hDEAD0005}};
    localparam logic [255:0] PAT_M5 = {8{32'h0BAD0005}};
    localparam logic [255:0] PAT_P7 = {8{32'hC0DE0007}};
    localparam logic [255:0] PAT_D9 = {8{32'h99990009}};
    localparam logic [255:0] PAT_M10 = {8{32'h1010AAAA}};
    localparam logic [255:0] PAT_JNK = {8{32'hFFFF0000}};
    localparam logic [255:0] PAT_M2 = {8{32'h22220002}};
    localparam logic [255:0] PAT_D2 = {8{32'h2222DDDD}};
    localparam logic [255:0] PAT_Q4 = {8{32'h44440004}};
    localparam logic [255:0] PAT_Q6 = {8{32'h66660006}};
    localparam logic [255:0] PAT_W8 = {8{32'h88880008}};

    always #5 clk = ~clk;

    data_memory_responder #(.LATENCY(10), .DEPTH_LOG2(9)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
        .data_i(din), .ack_o(ack), .data_o(dout)
    );

    data_memory_responder #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
        .data_i(din1), .ack_o(ack1), .data_o(dout1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard comparator for the LATENCY=10 instance.
    always @(negedge clk) begin : mon10
        exp_t e;
        if (rst) begin
            prev_ack10 <= 1'b0;
        end else begin
            if (ack) begin
                n_checks++;
                if (prev_ack10 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ack_width10: ack_o high twice in a row at cycle %0d", cyc);
                end
                if (sb10.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack10: ack_o=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = sb10.pop_front();
                    n_checks += 2;
                    if (cyc !== e.exp_cyc) begin
                        n_fail++;
                        $display("FAIL ack_cycle10: ack at cycle %0d, required %0d", cyc, e.exp_cyc);
                    end
                    if (dout !== e.data) begin
                        n_fail++;
                        $display("FAIL ack_data10: data_o=%h required %h", dout, e.data);
                    end
                end
            end
            prev_ack10 <= ack;
        end
    end

    // Scoreboard comparator for the LATENCY=1 instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            prev_ack1 <= 1'b0;
        end else begin
            if (ack1) begin
                n_checks++;
                if (prev_ack1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ack_width1: ack_o high twice in a row at cycle %0d", cyc);
                end
                if (sb1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack1: ack_o=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = sb1.pop_front();
                    n_checks += 2;
                    if (cyc !== e.exp_cyc) begin
                        n_fail++;
                        $display("FAIL ack_cycle1: ack at cycle %0d, required %0d", cyc, e.exp_cyc);
                    end
                    if (dout1 !== e.data) begin
                        n_fail++;
                        $display("FAIL ack_data1: data_o=%h required %h", dout1, e.data);
                    end
                end
            end
            prev_ack1 <= ack1;
        end
    end

    task automatic expect10(input logic w, input int due, input logic [255:0] rd);
        exp_t e;
        e.exp_cyc = due;
        if (w) begin
            e.data = last_rd10;
        end else begin
            e.data = rd;
            last_rd10 = rd;
        end
        sb10.push_back(e);
    endtask

    task automatic expect1(input logic w, input int due, input logic [255:0] rd);
        exp_t e;
        e.exp_cyc = due;
        if (w) begin
            e.data = last_rd1;
        end else begin
            e.data = rd;
            last_rd1 = rd;
        end
        sb1.push_back(e);
    endtask

    // Drive one single-cycle request on the LATENCY=10 instance (called at a negedge).
    task automatic issue10(input logic w, input logic [31:0] a, input logic [255:0] d,
                           input logic [255:0] rd);
        en = 1'b1; wr = w; addr = a; din = d;
        expect10(w, cyc + 10, rd);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic drain10(input string name);
        for (int i = 0; i < 60 && sb10.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb10.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d acks outstanding, required 0", name, sb10.size());
            sb10.delete();
        end
        @(negedge clk);
    endtask

    task automatic drain1(input string name);
        for (int i = 0; i < 20 && sb1.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d acks outstanding, required 0", name, sb1.size());
            sb1.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        dut.memory[3]  = PAT_A5;
        dut.memory[5]  = PAT_M5;
        dut.memory[7]  = PAT_P7;
        dut.memory[9]  = 256'd0;
        dut.memory[10] = PAT_M10;
        dut.memory[2]  = PAT_M2;
        dut1.memory[4] = PAT_Q4;
        dut1.memory[6] = PAT_Q6;
        @(negedge clk);
        n_checks += 4;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack10: %b required 0", ack); end
        if (dout !== 256'd0) begin n_fail++; $display("FAIL reset_data10: %h required 0", dout); end
        if (ack1 !== 1'b0) begin n_fail++; $display("FAIL reset_ack1: %b required 0", ack1); end
        if (dout1 !== 256'd0) begin n_fail++; $display("FAIL reset_data1: %h required 0", dout1); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        issue10(1'b0, 32'h0000_0060, PAT_JNK, PAT_A5);
        drain10("read");
        issue10(1'b0, 32'h8000_007F, PAT_JNK, PAT_A5);
        drain10("read_alias");
    endtask

    task automatic test_write_read();
        issue10(1'b1, 32'h0000_0020, 256'h1234, 256'd0);
        drain10("write");
        n_checks++;
        if (dut.memory[1] !== 256'h1234) begin
            n_fail++;
            $display("FAIL write_mem1: %h required %h", dut.memory[1], 256'h1234);
        end
        issue10(1'b0, 32'h0000_003F, PAT_JNK, 256'h1234);
        drain10("read_after_write");
    endtask

    task automatic test_back_to_back();
        int c0;
        int seen;
        c0 = cyc;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_00A0; din = PAT_D5;
        expect10(1'b1, c0 + 10, 256'd0);
        expect10(1'b0, c0 + 21, PAT_P7);
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (ack) seen = 1;
        end
        wr = 1'b0; addr = 32'h0000_00E0; din = PAT_JNK;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        drain10("back_to_back");
        n_checks++;
        if (dut.memory[5] !== PAT_D5) begin
            n_fail++;
            $display("FAIL writeback_mem5: %h required %h", dut.memory[5], PAT_D5);
        end
    endtask

    task automatic test_input_change();
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0120; din = PAT_D9;
        expect10(1'b1, cyc + 10, 256'd0);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        addr = 32'h0000_0140; din = PAT_JNK; wr = 1'b0;
        drain10("input_change");
        n_checks += 2;
        if (dut.memory[9] !== PAT_D9) begin
            n_fail++;
            $display("FAIL latched_mem9: %h required %h", dut.memory[9], PAT_D9);
        end
        if (dut.memory[10] !== PAT_M10) begin
            n_fail++;
            $display("FAIL untouched_mem10: %h required %h", dut.memory[10], PAT_M10);
        end
    endtask

    task automatic test_reset_abort();
        int acks;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0040; din = PAT_D2;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        last_rd10 = 256'd0;
        last_rd1 = 256'd0;
        n_checks += 2;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack: %b required 0", ack); end
        if (dout !== 256'd0) begin n_fail++; $display("FAIL abort_data: %h required 0", dout); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        n_checks += 3;
        if (acks !== 0) begin n_fail++; $display("FAIL abort_no_ack: %0d acks, required 0", acks); end
        if (dut.memory[2] !== PAT_M2) begin
            n_fail++;
            $display("FAIL abort_mem2: %h required %h", dut.memory[2], PAT_M2);
        end
        if (dout !== 256'd0) begin n_fail++; $display("FAIL abort_hold: %h required 0", dout); end
        // Accept on the very first edge after reset release.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue10(1'b0, 32'h0000_0040, PAT_JNK, PAT_M2);
        drain10("post_reset_read");
    endtask

    task automatic test_latency1();
        en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0080; din1 = PAT_JNK;
        expect1(1'b0, cyc + 1, PAT_Q4);
        expect1(1'b0, cyc + 3, PAT_Q6);
        @(negedge clk);
        addr1 = 32'h0000_00C0;
        @(negedge clk);
        @(negedge clk);
        en1 = 1'b0;
        drain1("lat1_reads");
        en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0100; din1 = PAT_W8;
        expect1(1'b1, cyc + 1, 256'd0);
        @(negedge clk);
        en1 = 1'b0;
        drain1("lat1_write");
        n_checks++;
        if (dut1.memory[8] !== PAT_W8) begin
            n_fail++;
            $display("FAIL lat1_mem8: %h required %h", dut1.memory[8], PAT_W8);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_input_change();
        test_reset_abort();
        test_latency1();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10: edges from request acceptance to ack_o assertion; legal range 1..255.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9: log2 of the number of 256-bit lines; the default gives 512 lines (16 KiB).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1 bit: request valid from the cache controller.
REQ-006 SHALL have port write_i, input, 1 bit: 1 = line write, 0 = line read; sampled with enable_i.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address; line index = addr_i[DEPTH_LOG2+4:5]; bits [4:0] and bits above the index are ignored (aliasing).
REQ-008 SHALL have port data_i, input, 256 bits: write line data; sampled with enable_i.
REQ-009 SHALL have port ack_o, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256 bits: read line data, valid while ack_o is high for a read.

Function
REQ-011 SHALL implement a state machine with states IDLE, WAIT and ACK, plus an 8-bit latency counter cnt.
REQ-012 In IDLE with enable_i=1 at an edge, SHALL do the following at that edge (the accept edge): latch write_i, the index and data_i; set cnt=1; go to WAIT (or go straight to ACK when LATENCY=1).
REQ-013 In IDLE with enable_i=0, SHALL stay in IDLE with ack_o=0.
REQ-014 In WAIT, SHALL increment cnt each edge; at the edge where cnt==LATENCY-1 it SHALL go to ACK.
REQ-015 ack_o SHALL be registered, high only in ACK, and first high exactly LATENCY cycles after the accept edge.
REQ-016 On the edge entering ACK for a read, SHALL load data_o with mem[latched index].
REQ-017 On the edge entering ACK for a write, SHALL write the latched data to mem[latched index]; data_o is unchanged.
REQ-018 data_o SHALL hold its last value until the next read completes.
REQ-019 Inputs enable_i, write_i, addr_i and data_i SHALL be ignored in WAIT and ACK; only latched values are used.
REQ-020 ACK SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-021 Any new request is sampled in IDLE no earlier than the cycle after ACK.
REQ-022 The cache may hold enable_i high across ACK (writeback then refill); the held request SHALL be accepted on the first IDLE edge after ACK.
REQ-023 A read after a write to the same index SHALL return the written data; there is no bypass, and ordering follows from serialisation.
REQ-024 Only one request SHALL be outstanding; there is no queueing.
REQ-025 The memory array SHALL NOT be reset; the bench initialises it via hierarchical access to the array named memory.

Reset
REQ-026 While rst_i=1, asynchronously: state=IDLE, cnt=0, ack_o=0, data_o=0, latched command cleared.
REQ-027 Reset asserted mid-operation (WAIT or ACK before the commit edge) SHALL abort the request; no array write occurs and no ack_o is produced.
REQ-028 On the first edge after rst_i deasserts, a request with enable_i=1 SHALL be accepted.

Verification
REQ-029 Read, LATENCY=10: preload memory[3]=256'hA5..A5; enable_i=1, write_i=0, addr_i=32'h60 -> ack_o high exactly on cycle 10 after the accept edge, for one cycle; data_o=A5..A5.
REQ-030 Write then read: write 256'h1234 to addr 32'h20 -> ack after 10 cycles; then a read of 32'h3F -> data_o=256'h1234 (offset bits ignored).
REQ-031 Writeback then refill, enable_i held high continuously: write to idx 5, then read idx 7 with write_i dropped the cycle after ack -> two acks 11 cycles apart; memory[5] updated; read returns memory[7].
REQ-032 Input change during WAIT: change addr_i and data_i on cycle 4 of a write -> only the originally latched index is written, with the original data.
REQ-033 Reset mid-write: assert rst_i at cycle 5 of a write to idx 2 -> ack_o never rises; memory[2] unchanged; data_o=0.
REQ-034 LATENCY=1 build: read request -> ack_o high on the cycle immediately after the accept edge; next request accepted the following cycle.
